mm_param_core: RTL
==================

# mm_param_core

Parametrised, mode-extended successor of the fixed 8x8 matrix-multiply engine. It holds three internal RAMs: A and B are loaded over a write port, and C is computed by one sequential MAC per cycle and read back over a registered read port. It adds generic dimension and data width, an accumulate mode (C += A×B) with saturation, a B-transpose mode, and a `busy`/`err` status pair. It sits behind `mm_ifc`, driven by the UVM-lite generator/scoreboard flow.

## Interface
- `N`, 8: matrix dimension; power of two, 2..16.
- `DW`, 8: signed element width of A and B.
- `AW` (localparam), 2·log2(N): RAM address width.
- `CW` (localparam), 2·DW + log2(N): signed C width; 19 at defaults.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `load_mem` in 1: enables the external RAM ports.
- `wenA`, `wenB` in 1: write enables, qualified by `load_mem`.
- `addrA`, `addrB` in AW: row-major write address, row·N+col.
- `wdA`, `wdB` in DW: signed write data.
- `addrC` in AW: external C read address.
- `rdC` out CW: registered C read data.
- `start` in 1: single-cycle request to begin multiply.
- `acc_mode` in 1: sampled with `start`; 0 gives C=A×B, 1 gives C=sat(C+A×B).
- `trans_b` in 1: sampled with `start`; 1 uses Bᵀ, so B[j][k] is read instead of B[k][j].
- `busy` out 1: high while computing.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky protocol-error flag.

## Operation
- Reset values: `busy`=0, `done`=0, `err`=0, `rdC`=0. FSM returns to IDLE. RAM contents are not cleared: A/B/C keep their data, and power-up contents are undefined.
- IDLE:
  - A/B writes occur when `load_mem`&`wenX`.
  - `rdC` ← C[`addrC`] every cycle, with 1-cycle latency.
  - `start`=1 latches `acc_mode` and `trans_b`, clears `err`, sets i=j=0, and goes to INIT.
- INIT (1 cycle): issue reads A[i][0], B[0][j] (or B[j][0]), and C[i][j].
- MAC (N cycles, m=0..N-1):
  - acc ← (m==0 ? (acc_mode ? C[i][j] : 0) : acc) + A[i][m]·B[m][j].
  - Issue the k=m+1 reads (ignored at m=N-1).
- WB (1 cycle): write C[i][j] ← acc. Then advance j, wrapping to j=0 with i++, and go to INIT. After (N-1,N-1), go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0, then IDLE.
- Arithmetic:
  - Products are full 2·DW signed.
  - acc is CW+1 bits internally.
  - In WB, acc saturates to [−2^(CW−1), 2^(CW−1)−1]. Overwrite mode cannot overflow; accumulate mode can.
- While `busy`:
  - External writes and `addrC` are ignored; `rdC` holds its last value.
  - `start` or `load_mem`&(`wenA`|`wenB`) sets `err` and has no other effect.
- `start` in the DONE cycle is accepted normally and begins a new run the next cycle.
- `reset` mid-run aborts immediately. Partially written C is left as-is; no `done` is issued.

## Timing
- `start` sampled high at edge t: `busy`=1 from t+1; INIT begins at t+1.
- Per element: N+2 cycles. Total compute: N²·(N+2) cycles.
- `done` is high for exactly the cycle after the last WB, i.e. at edge t+1+N²(N+2). With N=8 this is t+641.
- `busy` falls in the same cycle `done` rises.
- External `addrC` at edge u gives `rdC` valid after edge u+1.
- A write at edge u is readable by an internal read issued at u+1 or later.

## Structure
- Package `mm_pkg`:
  - `mm_state_e` {IDLE, INIT, MAC, WB, DONE}.
  - Default N/DW.
  - Function `sat_cw()`.
  - Helper `idx(row,col,N)`.
- Sub-module `mm_ram` (params DEPTH, WIDTH): one synchronous write, one synchronous 1-cycle read. Instanced three times (A, B, C).
- Each read address is a mux between the external address (IDLE) and FSM-generated addresses (busy).
- The C write port is internal only.

## Test plan
- **Identity:** A=I, B[r][c]=r·8+c−32, overwrite → C==B exactly; `done` pulse 641 cycles after `start`.
- **Accumulate/saturate, positive:** all A=B=127, N=8. First run gives C=129032 everywhere. acc_mode=1 run gives 258064. Third run saturates to 262143.
- **Accumulate/saturate, negative:** A=−128, B=127. Sequence is −130048, then −260096, then saturated −262144.
- **Transpose:** random A,B with trans_b=1 → C==A×Bᵀ per scoreboard. Then trans_b=0 on the same data → C==A×B.
- **Protocol error:** `start` and `wenA` pulsed mid-run → `err`=1, A unchanged, result and `done` timing unaffected. Next accepted `start` clears `err`.
- **Reset mid-run and generic build:** `reset` at cycle 300 → `busy`=`done`=0 next cycle, A/B intact, rerun correct. Repeat 100 random runs at N=4, DW=6 (CW=14, done at t+97).

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and arithmetic helpers for the parametrised matrix-multiply engine.
package mm_pkg;

  localparam int N_DEF  = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {IDLE, INIT, MAC, WB, DONE} mm_state_e;

  // Clamp a sign-extended value into the signed range of a cw-bit result.
  function automatic logic signed [63:0] sat_cw(input logic signed [63:0] v, input int cw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (cw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mm_ifc.sv
// Load / start / read-back bus of the matrix-multiply engine.
interface mm_ifc
  import mm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
);
  localparam int AW = 2 * $clog2(N);
  localparam int CW = 2 * DW + $clog2(N);

  logic          load_mem;
  logic          wenA;
  logic          wenB;
  logic [AW-1:0] addrA;
  logic [AW-1:0] addrB;
  logic [DW-1:0] wdA;
  logic [DW-1:0] wdB;
  logic [AW-1:0] addrC;
  logic [CW-1:0] rdC;
  logic          start;
  logic          acc_mode;
  logic          trans_b;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output load_mem, wenA, wenB, addrA, addrB, wdA, wdB, addrC, start, acc_mode, trans_b,
    input  rdC, busy, done, err
  );

  modport slave (
    input  load_mem, wenA, wenB, addrA, addrB, wdA, wdB, addrC, start, acc_mode, trans_b,
    output rdC, busy, done, err
  );

endinterface

// File: rtl/mm_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module mm_ram
  import mm_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/mm_param_core.sv
// N x N signed matrix multiply, one MAC per cycle, with accumulate/saturate and B-transpose modes.
module mm_param_core
  import mm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input logic  clk,
  input logic  reset,
  mm_ifc.slave bus
);

  localparam int LG  = $clog2(N);
  localparam int AW  = 2 * LG;
  localparam int CW  = 2 * DW + LG;
  localparam int PW  = 2 * DW;
  localparam int ACW = CW + 1;
  localparam logic [LG-1:0] LAST = LG'(N - 1);

  mm_state_e             state;
  logic [LG-1:0]         i, j, m;
  logic                  acc_q, trans_q;
  logic signed [ACW-1:0] acc;
  logic                  ext_q;
  logic [CW-1:0]         c_hold;

  logic                  ext, wr_attempt;
  logic [LG-1:0]         k;
  logic [AW-1:0]         a_raddr, b_raddr, c_raddr;
  logic [DW-1:0]         a_rd, b_rd;
  logic [CW-1:0]         c_rd, c_wd;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] base;

  // External ports own the RAMs only while no element is in flight.
  assign ext        = (state == IDLE) || (state == DONE);
  assign wr_attempt = !ext && (bus.start || (bus.load_mem && (bus.wenA || bus.wenB)));

  // Read address for the next k: 0 while priming in INIT, m+1 during MAC.
  assign k       = (state == MAC) ? m + LG'(1) : '0;
  assign a_raddr = {i, k};
  assign b_raddr = trans_q ? {j, k} : {k, j};
  assign c_raddr = ext ? bus.addrC : {i, j};

  assign prod = PW'($signed(a_rd)) * PW'($signed(b_rd));
  assign base = (m != '0) ? acc : (acc_q ? ACW'($signed(c_rd)) : '0);
  assign c_wd = CW'(sat_cw(64'(acc), CW));

  mm_ram #(.DEPTH(N * N), .WIDTH(DW)) u_ram_a (
    .clk, .reset,
    .we(ext && bus.load_mem && bus.wenA), .waddr(bus.addrA), .wdata(bus.wdA),
    .raddr(a_raddr), .rdata(a_rd)
  );

  mm_ram #(.DEPTH(N * N), .WIDTH(DW)) u_ram_b (
    .clk, .reset,
    .we(ext && bus.load_mem && bus.wenB), .waddr(bus.addrB), .wdata(bus.wdB),
    .raddr(b_raddr), .rdata(b_rd)
  );

  mm_ram #(.DEPTH(N * N), .WIDTH(CW)) u_ram_c (
    .clk, .reset,
    .we(state == WB), .waddr({i, j}), .wdata(c_wd),
    .raddr(c_raddr), .rdata(c_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      i       <= '0;
      j       <= '0;
      m       <= '0;
      acc     <= '0;
      acc_q   <= 1'b0;
      trans_q <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            acc_q    <= bus.acc_mode;
            trans_q  <= bus.trans_b;
            bus.err  <= 1'b0;
            i        <= '0;
            j        <= '0;
            state    <= INIT;
            bus.busy <= 1'b1;
          end
        end
        INIT: begin
          m     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= base + ACW'(prod);
          m   <= m + LG'(1);
          if (m == LAST) state <= WB;
        end
        WB: begin
          j     <= j + LG'(1);
          state <= INIT;
          if (j == LAST) begin
            i <= i + LG'(1);
            if (i == LAST) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_attempt) bus.err <= 1'b1;
    end
  end

  // rdC follows the C RAM only when its last read was external; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q  <= 1'b0;
      c_hold <= '0;
    end else begin
      ext_q <= ext;
      if (ext_q) c_hold <= c_rd;
    end
  end

  assign bus.rdC = ext_q ? c_rd : c_hold;

endmodule
